// File: rtl/fp16_to_fix.sv
// fp16 -> signed W-bit fixed point (F fractional bits), RNE rounding with saturation.
// Latency: s+1 edges from accept to out_valid; s = shift cycles (0 for specials and k=0).
// Backpressure: one operand in flight; in_ready only in IDLE; OUT holds until out_ready.
module fp16_to_fix #(
   parameter int W = 16,
   parameter int F = 0
) (
   input  logic         CLK,
   input  logic         RESETn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [15:0]  in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [3:0]   out_flags
);

   typedef enum logic [2:0] {IDLE, LSHIFT, RSHIFT, ROUND, OUT} state_t;
   // Preset result class chosen at accept time; K_NORM goes through rounding.
   typedef enum logic [1:0] {K_NORM, K_NAN, K_SAT, K_ZERO} kind_t;

   localparam logic signed [7:0] F_S  = 8'(F);
   localparam logic signed [7:0] WM1  = 8'(W - 1);
   localparam logic [W:0]        MAXP = {2'b00, {(W-1){1'b1}}};
   localparam logic [W:0]        MINM = {2'b01, {(W-1){1'b0}}};
   localparam logic [W-1:0]      SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]      SMIN = {1'b1, {(W-1){1'b0}}};

   state_t       state_q, state_d;
   kind_t        kind_q, kind_d;
   logic         sign_q, sign_d;
   logic [W:0]   mag_q, mag_d;
   logic         guard_q, guard_d;
   logic         sticky_q, sticky_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [W-1:0] data_q, data_d;
   logic [3:0]   flags_q, flags_d;
   logic         rdy_q, rdy_d;

   // operand decode (only meaningful on the accept cycle)
   logic [4:0]        ex;
   logic [9:0]        mt;
   logic [10:0]       sig;
   logic [4:0]        e_eff;
   logic signed [7:0] ee;     // exponent of the leading bit in the output scale
   logic signed [7:0] k;      // left-shift amount applied to the 11-bit significand
   logic signed [7:0] nk;
   logic              accept;

   assign ex     = in_data[14:10];
   assign mt     = in_data[9:0];
   assign sig    = {(ex != 5'd0), mt};
   assign e_eff  = (ex == 5'd0) ? 5'd1 : ex;
   assign ee     = $signed({3'b000, e_eff}) + F_S - 8'sd15;
   assign k      = ee - 8'sd10;
   assign nk     = -k;
   assign accept = in_valid & rdy_q;

   // rounding datapath used in ROUND
   logic         inc;
   logic [W:0]   m_rnd;
   logic [W-1:0] m_neg;
   logic [W-1:0] res;
   logic         ovf;

   assign inc   = guard_q & (sticky_q | mag_q[0]);
   assign m_rnd = mag_q + {{W{1'b0}}, inc};
   assign m_neg = -(m_rnd[W-1:0]);

   assign in_ready  = rdy_q;
   assign out_valid = (state_q == OUT);
   assign out_data  = data_q;
   assign out_flags = flags_q;

   // state and datapath registers; reset aborts any conversion in flight
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= IDLE;
         kind_q   <= K_NORM;
         sign_q   <= 1'b0;
         mag_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         data_q   <= '0;
         flags_q  <= '0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         sign_q   <= sign_d;
         mag_q    <= mag_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         flags_q  <= flags_d;
         rdy_q    <= rdy_d;
      end
   end

   // next-state and datapath update for each FSM state
   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      flags_d  = flags_q;
      res      = '0;
      ovf      = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               sign_d   = in_data[15];
               mag_d    = (W+1)'(sig);
               guard_d  = 1'b0;
               sticky_d = 1'b0;
               kind_d   = K_NORM;
               cnt_d    = '0;
               if (ex == 5'd31) begin
                  kind_d  = (mt != 10'd0) ? K_NAN : K_SAT;
                  state_d = ROUND;
               end else if ((ee >= WM1) && !(in_data[15] && (mt == 10'd0) && (ee == WM1))) begin
                  // magnitude >= 2^(W-1); only exactly -2^(W-1) is representable
                  kind_d  = K_SAT;
                  state_d = ROUND;
               end else if ((ex == 5'd0) && (mt == 10'd0)) begin
                  kind_d  = K_ZERO;
                  state_d = ROUND;
               end else if (k > 8'sd0) begin
                  cnt_d   = 5'(k);
                  state_d = LSHIFT;
               end else if (k < 8'sd0) begin
                  // beyond 12 shifts the 11-bit significand is fully in guard/sticky
                  cnt_d   = (nk > 8'sd12) ? 5'd12 : 5'(nk);
                  state_d = RSHIFT;
               end else begin
                  state_d = ROUND;
               end
            end
         end
         LSHIFT: begin
            mag_d = {mag_q[W-1:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = ROUND;
         end
         RSHIFT: begin
            mag_d    = {1'b0, mag_q[W:1]};
            guard_d  = mag_q[0];
            sticky_d = sticky_q | guard_q;
            cnt_d    = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = ROUND;
         end
         ROUND: begin
            case (kind_q)
               K_NAN: begin
                  data_d  = '0;
                  flags_d = 4'b1000;
               end
               K_SAT: begin
                  data_d  = sign_q ? SMIN : SMAX;
                  flags_d = 4'b0100;
               end
               K_ZERO: begin
                  data_d  = '0;
                  flags_d = 4'b0001;
               end
               default: begin
                  if (!sign_q && (m_rnd > MAXP)) begin
                     res = SMAX;
                     ovf = 1'b1;
                  end else if (sign_q && (m_rnd > MINM)) begin
                     res = SMIN;
                     ovf = 1'b1;
                  end else begin
                     res = sign_q ? m_neg : m_rnd[W-1:0];
                  end
                  data_d  = res;
                  flags_d = {1'b0, ovf, (guard_q | sticky_q), (res == '0)};
               end
            endcase
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      rdy_d = (state_d == IDLE);
   end

endmodule

// File: tb/tb_fp16_to_fix.sv
// Bench for fp16_to_fix: directed cases plus random operands against an arithmetic reference.
// Two instances (F=0 and F=8, W=16) share clock, reset and in_data; one is driven at a time.
// Checks result, flags, latency, OUT hold under backpressure, and reset abort.
module tb_fp16_to_fix;

   localparam int W = 16;

   logic          CLK = 1'b0;
   logic          RESETn = 1'b0;
   logic [15:0]   in_data = 16'h0000;
   logic          iv = 1'b0;
   logic          ordy = 1'b0;
   int            sel = 0;

   logic          in_valid0, in_ready0, out_valid0, out_ready0;
   logic [W-1:0]  out_data0;
   logic [3:0]    out_flags0;
   logic          in_valid1, in_ready1, out_valid1, out_ready1;
   logic [W-1:0]  out_data1;
   logic [3:0]    out_flags1;

   logic          in_ready_s, out_valid_s;
   logic [W-1:0]  out_data_s;
   logic [3:0]    out_flags_s;

   int checks = 0;
   int errors = 0;

   assign in_valid0  = iv && (sel == 0);
   assign out_ready0 = ordy && (sel == 0);
   assign in_valid1  = iv && (sel != 0);
   assign out_ready1 = ordy && (sel != 0);

   assign in_ready_s  = (sel != 0) ? in_ready1   : in_ready0;
   assign out_valid_s = (sel != 0) ? out_valid1  : out_valid0;
   assign out_data_s  = (sel != 0) ? out_data1   : out_data0;
   assign out_flags_s = (sel != 0) ? out_flags1  : out_flags0;

   fp16_to_fix #(.W(W), .F(0)) dut0 (
      .CLK(CLK), .RESETn(RESETn),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .out_data(out_data0), .out_flags(out_flags0)
   );

   fp16_to_fix #(.W(W), .F(8)) dut1 (
      .CLK(CLK), .RESETn(RESETn),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_data(out_data1), .out_flags(out_flags1)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Exact arithmetic reference: value = sig * 2^(e-25+f), RNE, then saturate to W bits.
   // s = number of shift cycles the converter spends before ROUND.
   function automatic void model(input logic [15:0] d, input int f,
                                 output logic [15:0] data, output logic [3:0] flags,
                                 output int s);
      logic        sgn;
      int          ex, mt, sig, e, k, sh;
      longint      q, rem, half, v, maxv, minv;
      logic        ov;
      sgn  = d[15];
      ex   = int'(d[14:10]);
      mt   = int'(d[9:0]);
      maxv = (longint'(1) << (W - 1)) - 1;
      minv = -(longint'(1) << (W - 1));
      s    = 0;
      if (ex == 31) begin
         if (mt != 0) begin
            data  = 16'h0000;
            flags = 4'b1000;
         end else begin
            data  = sgn ? 16'(minv) : 16'(maxv);
            flags = 4'b0100;
         end
         return;
      end
      if (ex == 0 && mt == 0) begin
         data  = 16'h0000;
         flags = 4'b0001;
         return;
      end
      sig = (ex != 0 ? 1024 : 0) + mt;
      e   = (ex == 0) ? 1 : ex;
      k   = e - 25 + f;
      rem = 0;
      if (k >= 0) begin
         q = longint'(sig) << k;
         s = k;
      end else begin
         sh   = -k;
         q    = longint'(sig) >> sh;
         rem  = longint'(sig) - (q << sh);
         half = longint'(1) << (sh - 1);
         if (rem > half || (rem == half && q[0])) q++;
         s = (sh > 12) ? 12 : sh;
      end
      // values too large to represent skip the shifter entirely
      if (q > maxv + 1 || (q == maxv + 1 && !sgn)) s = 0;
      v  = sgn ? -q : q;
      ov = 1'b0;
      if (v > maxv) begin
         v  = maxv;
         ov = 1'b1;
      end else if (v < minv) begin
         v  = minv;
         ov = 1'b1;
      end
      data  = 16'(v);
      flags = {1'b0, ov, (rem != 0), (data == 16'h0000)};
   endfunction

   // One full conversion on instance dsel: accept, wait for result, optional
   // backpressure of 'hold' cycles, then handshake. tab=1 adds fixed expectations.
   task automatic convert(input string tag, input int dsel, input logic [15:0] d,
                          input int hold, input bit tab,
                          input logic [15:0] td, input logic [3:0] tf);
      logic [15:0] md;
      logic [3:0]  mf;
      int          ms, lat;
      sel = dsel;
      model(d, (dsel != 0) ? 8 : 0, md, mf, ms);
      lat = 0;
      while (!in_ready_s && lat < 50) begin
         step();
         lat++;
      end
      chk({tag, "/in_ready"}, 32'(in_ready_s), 32'd1);
      in_data = d;
      iv      = 1'b1;
      step();                       // accept edge
      iv      = 1'b0;
      in_data = 16'($urandom);      // must be ignored from here on
      lat = 0;
      while (!out_valid_s && lat < 100) begin
         step();
         lat++;
      end
      chk({tag, "/out_valid"}, 32'(out_valid_s), 32'd1);
      chk({tag, "/latency"}, 32'(lat), 32'(ms + 1));
      chk({tag, "/data"}, 32'(out_data_s), 32'(md));
      chk({tag, "/flags"}, 32'(out_flags_s), 32'(mf));
      if (tab) begin
         chk({tag, "/data_tab"}, 32'(out_data_s), 32'(td));
         chk({tag, "/flags_tab"}, 32'(out_flags_s), 32'(tf));
      end
      for (int h = 0; h < hold; h++) begin
         step();
         chk({tag, "/hold_data"}, 32'(out_data_s), 32'(md));
         chk({tag, "/hold_valid"}, 32'(out_valid_s), 32'd1);
         chk({tag, "/hold_in_ready"}, 32'(in_ready_s), 32'd0);
      end
      ordy = 1'b1;
      step();
      ordy = 1'b0;
      chk({tag, "/post_valid"}, 32'(out_valid_s), 32'd0);
      chk({tag, "/post_in_ready"}, 32'(in_ready_s), 32'd1);
   endtask

   initial begin
      // reset state
      step();
      step();
      sel = 0;
      chk("rst_in_ready0", 32'(in_ready0), 32'd0);
      chk("rst_out_valid0", 32'(out_valid0), 32'd0);
      chk("rst_out_data0", 32'(out_data0), 32'd0);
      chk("rst_out_flags0", 32'(out_flags0), 32'd0);
      chk("rst_in_ready1", 32'(in_ready1), 32'd0);
      RESETn = 1'b1;
      #1;
      chk("rel_in_ready_before_edge", 32'(in_ready0), 32'd0);
      step();
      chk("rel_in_ready_after_edge", 32'(in_ready0), 32'd1);

      // directed cases, W=16 F=0
      convert("one",      0, 16'h3C00, 0, 1'b1, 16'h0001, 4'b0000);
      convert("one_half", 0, 16'h3E00, 0, 1'b1, 16'h0002, 4'b0010);
      convert("two_half", 0, 16'h4100, 0, 1'b1, 16'h0002, 4'b0010);
      convert("neg_five", 0, 16'hC500, 0, 1'b1, 16'hFFFB, 4'b0000);
      convert("big_pos",  0, 16'h7800, 5, 1'b1, 16'h7FFF, 4'b0100);
      convert("big_neg",  0, 16'hF800, 0, 1'b1, 16'h8000, 4'b0000);
      convert("pinf",     0, 16'h7C00, 0, 1'b1, 16'h7FFF, 4'b0100);
      convert("ninf",     0, 16'hFC00, 0, 1'b1, 16'h8000, 4'b0100);
      convert("nan",      0, 16'h7E00, 0, 1'b1, 16'h0000, 4'b1000);
      convert("nzero",    0, 16'h8000, 0, 1'b1, 16'h0000, 4'b0001);
      convert("subnorm",  0, 16'h0001, 0, 1'b1, 16'h0000, 4'b0011);
      convert("neg_half", 0, 16'hB800, 2, 1'b1, 16'h0000, 4'b0011);
      convert("three_half", 0, 16'h3A00, 0, 1'b1, 16'h0001, 4'b0010);

      // fractional output, W=16 F=8
      convert("frac_1p5", 1, 16'h3E00, 0, 1'b1, 16'h0180, 4'b0000);
      convert("frac_big", 1, 16'h5800, 0, 1'b1, 16'h7FFF, 4'b0100);
      convert("frac_nmax", 1, 16'hD800, 0, 1'b1, 16'h8000, 4'b0000);

      // reset during RSHIFT aborts the conversion
      sel     = 0;
      in_data = 16'h3C00;
      iv      = 1'b1;
      step();
      iv      = 1'b0;
      step();
      step();
      step();
      RESETn = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid0), 32'd0);
      chk("abort_in_ready", 32'(in_ready0), 32'd0);
      chk("abort_out_data", 32'(out_data0), 32'd0);
      step();
      chk("abort_in_ready_held", 32'(in_ready0), 32'd0);
      chk("abort_out_valid_held", 32'(out_valid0), 32'd0);
      RESETn = 1'b1;
      step();
      chk("abort_in_ready_release", 32'(in_ready0), 32'd1);
      convert("post_rst", 0, 16'h4000, 0, 1'b1, 16'h0002, 4'b0000);

      // random operands on both instances
      for (int i = 0; i < 200; i++) begin
         logic [15:0] d;
         d = 16'($urandom);
         if (i % 4 == 3) d[14:10] = 5'($urandom_range(10, 31));
         convert($sformatf("rand%0d", i), i % 2, d, $urandom_range(0, 2),
                 1'b0, 16'h0000, 4'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
